// File: rtl/vga_pkg.sv
// Shared VGA defaults (640x480@60), pixel format, sync polarity constants and the dim helper.
package vga_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   localparam int COLOR_W = 12;
   localparam int CHAN_W  = COLOR_W / 3;
   localparam logic [COLOR_W-1:0] TRANSP_KEY = 12'hF0F;

   localparam logic SYNC_ACTIVE_LOW  = 1'b0;
   localparam logic SYNC_ACTIVE_HIGH = 1'b1;

   // Halve every colour channel independently; the dropped LSB is simply truncated.
   function automatic logic [COLOR_W-1:0] dim_pixel(input logic [COLOR_W-1:0] pix);
      logic [COLOR_W-1:0] dim;
      dim = '0;
      for (int c = 0; c < 3; c++) begin
         dim[c*CHAN_W +: CHAN_W] = pix[c*CHAN_W +: CHAN_W] >> 1;
      end
      return dim;
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters advancing on pix_ce, with combinational active-video, frame and sync-window decodes.
module vga_timing_gen #(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE_DEF,
   parameter int H_FP     = vga_pkg::H_FP_DEF,
   parameter int H_SYNC   = vga_pkg::H_SYNC_DEF,
   parameter int H_BP     = vga_pkg::H_BP_DEF,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE_DEF,
   parameter int V_FP     = vga_pkg::V_FP_DEF,
   parameter int V_SYNC   = vga_pkg::V_SYNC_DEF,
   parameter int V_BP     = vga_pkg::V_BP_DEF
) (
   input  logic       clka,
   input  logic       rst,
   input  logic       pix_ce,
   output logic [9:0] h_cnt,
   output logic [9:0] v_cnt,
   output logic       valid,
   output logic       frame_start,
   output logic       frame_end,
   output logic       hsync_win,
   output logic       vsync_win
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_chk
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit 10-bit counters");
   end

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;
   logic       h_last, v_last;

   assign h_last = (h_cnt_q == H_LAST);
   assign v_last = (v_cnt_q == V_LAST);

   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (pix_ce) begin
         if (h_last) begin
            h_cnt_d = '0;
            v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clka or negedge rst) begin
      if (!rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   assign h_cnt       = h_cnt_q;
   assign v_cnt       = v_cnt_q;
   assign valid       = (h_cnt_q < 10'(H_ACTIVE)) && (v_cnt_q < 10'(V_ACTIVE));
   assign frame_start = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
   assign frame_end   = pix_ce && h_last && v_last;
   assign hsync_win   = (h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END);
   assign vsync_win   = (v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END);

endmodule

// File: rtl/vga_layer_compositor.sv
// VGA timing plus NUM_LAYERS priority compositor (enable, blink, dim, colour-key per layer).
// rgb_out, hsync and vsync are registered together, one pix_ce behind h_cnt/v_cnt.
module vga_layer_compositor #(
   parameter int H_ACTIVE     = vga_pkg::H_ACTIVE_DEF,
   parameter int H_FP         = vga_pkg::H_FP_DEF,
   parameter int H_SYNC       = vga_pkg::H_SYNC_DEF,
   parameter int H_BP         = vga_pkg::H_BP_DEF,
   parameter int V_ACTIVE     = vga_pkg::V_ACTIVE_DEF,
   parameter int V_FP         = vga_pkg::V_FP_DEF,
   parameter int V_SYNC       = vga_pkg::V_SYNC_DEF,
   parameter int V_BP         = vga_pkg::V_BP_DEF,
   parameter int NUM_LAYERS   = 4,
   parameter int COLOR_W      = vga_pkg::COLOR_W,
   parameter logic [COLOR_W-1:0] TRANSP_KEY = vga_pkg::TRANSP_KEY,
   parameter int BLINK_FRAMES = 30,
   parameter logic SYNC_POL   = vga_pkg::SYNC_ACTIVE_LOW
) (
   input  logic                          clka,
   input  logic                          rst,
   input  logic                          pix_ce,
   input  logic [NUM_LAYERS*COLOR_W-1:0] layer_pixel,
   input  logic [NUM_LAYERS-1:0]         layer_en,
   input  logic [NUM_LAYERS-1:0]         layer_key_en,
   input  logic [NUM_LAYERS-1:0]         layer_blink,
   input  logic [NUM_LAYERS-1:0]         layer_dim,
   input  logic [COLOR_W-1:0]            bg_pixel,
   output logic [9:0]                    h_cnt,
   output logic [9:0]                    v_cnt,
   output logic                          valid,
   output logic                          frame_start,
   output logic [COLOR_W-1:0]            rgb_out,
   output logic                          hsync,
   output logic                          vsync
);
   import vga_pkg::*;

   if (COLOR_W != vga_pkg::COLOR_W || BLINK_FRAMES < 1) begin : g_param_chk
      $error("vga_layer_compositor: COLOR_W must match vga_pkg and BLINK_FRAMES must be >= 1");
   end

   localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

   logic frame_end_w, hsync_win_w, vsync_win_w;

   vga_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clka        (clka),
      .rst         (rst),
      .pix_ce      (pix_ce),
      .h_cnt       (h_cnt),
      .v_cnt       (v_cnt),
      .valid       (valid),
      .frame_start (frame_start),
      .frame_end   (frame_end_w),
      .hsync_win   (hsync_win_w),
      .vsync_win   (vsync_win_w)
   );

   logic [FC_W-1:0]    fcnt_q, fcnt_d;
   logic               blink_q, blink_d;
   logic [COLOR_W-1:0] rgb_q, rgb_d, pix_sel;
   logic               hsync_q, hsync_d, vsync_q, vsync_d;

   // Walk from lowest priority upward so the lowest-index visible layer is the last writer.
   always_comb begin
      pix_sel = bg_pixel;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (layer_en[i] && !(layer_blink[i] && blink_q) &&
             !(layer_key_en[i] && (layer_pixel[i*COLOR_W +: COLOR_W] == TRANSP_KEY))) begin
            pix_sel = layer_dim[i] ? dim_pixel(layer_pixel[i*COLOR_W +: COLOR_W])
                                   : layer_pixel[i*COLOR_W +: COLOR_W];
         end
      end
   end

   always_comb begin
      rgb_d   = rgb_q;
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      fcnt_d  = fcnt_q;
      blink_d = blink_q;
      if (pix_ce) begin
         rgb_d   = valid ? pix_sel : '0;
         hsync_d = hsync_win_w ? SYNC_POL : ~SYNC_POL;
         vsync_d = vsync_win_w ? SYNC_POL : ~SYNC_POL;
      end
      // Frames are counted at the wrap into (0,0), so the frame leaving reset is frame 0.
      if (frame_end_w) begin
         if (fcnt_q == FC_LAST) begin
            fcnt_d  = '0;
            blink_d = ~blink_q;
         end else begin
            fcnt_d = fcnt_q + FC_W'(1);
         end
      end
   end

   always_ff @(posedge clka or negedge rst) begin
      if (!rst) begin
         fcnt_q  <= '0;
         blink_q <= 1'b0;
         rgb_q   <= '0;
         hsync_q <= ~SYNC_POL;
         vsync_q <= ~SYNC_POL;
      end else begin
         fcnt_q  <= fcnt_d;
         blink_q <= blink_d;
         rgb_q   <= rgb_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

   assign rgb_out = rgb_q;
   assign hsync   = hsync_q;
   assign vsync   = vsync_q;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Randomised, self-checking bench for vga_layer_compositor on a reduced raster so whole frames stay short.
module tb_vga_layer_compositor;

   localparam int HA = 16, HF = 4, HS = 6, HB = 4;
   localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int NL = 4, CW = 12, BF = 2;
   localparam logic POL = 1'b0;
   localparam logic [11:0] KEY = 12'hF0F;

   logic           clka = 1'b0;
   logic           rst = 1'b0;
   logic           pix_ce = 1'b0;
   logic [NL*CW-1:0] layer_pixel = '0;
   logic [NL-1:0]  layer_en = '0, layer_key_en = '0, layer_blink = '0, layer_dim = '0;
   logic [CW-1:0]  bg_pixel = '0;
   logic [9:0]     h_cnt, v_cnt;
   logic           valid, frame_start, hsync, vsync;
   logic [CW-1:0]  rgb_out;

   int checks = 0;
   int fails  = 0;
   int n      = 0;
   logic [11:0] exp_rgb = '0;
   logic        exp_hs = ~POL, exp_vs = ~POL;

   vga_layer_compositor #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .NUM_LAYERS(NL), .COLOR_W(CW), .TRANSP_KEY(KEY),
      .BLINK_FRAMES(BF), .SYNC_POL(POL)
   ) dut (
      .clka(clka), .rst(rst), .pix_ce(pix_ce),
      .layer_pixel(layer_pixel), .layer_en(layer_en), .layer_key_en(layer_key_en),
      .layer_blink(layer_blink), .layer_dim(layer_dim), .bg_pixel(bg_pixel),
      .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid), .frame_start(frame_start),
      .rgb_out(rgb_out), .hsync(hsync), .vsync(vsync)
   );

   always #5 clka = ~clka;

   // Reference: search layers from index 0 for the first visible one.
   function automatic logic [11:0] compose(input logic [NL*CW-1:0] px, input logic [NL-1:0] en,
                                           input logic [NL-1:0] key, input logic [NL-1:0] bl,
                                           input logic [NL-1:0] dm, input logic [11:0] bg, input bit ph);
      for (int i = 0; i < NL; i++) begin
         logic [11:0] p;
         p = px[i*CW +: CW];
         if (en[i] && !(bl[i] && ph) && !(key[i] && p == KEY)) begin
            if (dm[i]) return {4'(p[11:8] / 2), 4'(p[7:4] / 2), 4'(p[3:0] / 2)};
            return p;
         end
      end
      return bg;
   endfunction

   function automatic bit phase_of(input int cnt);
      return ((cnt / FT) / BF) % 2 == 1;
   endfunction

   function automatic logic [35:0] exp_status();
      int h, v;
      h = n % HT;
      v = (n / HT) % VT;
      return {10'(h), 10'(v), (h < HA && v < VA), (h == 0 && v == 0), exp_hs, exp_vs, exp_rgb};
   endfunction

   task automatic rand_inputs();
      for (int i = 0; i < NL; i++)
         layer_pixel[i*CW +: CW] = ($urandom_range(0, 3) == 0) ? KEY : CW'($urandom);
      layer_en     = NL'($urandom);
      layer_key_en = NL'($urandom);
      layer_blink  = NL'($urandom);
      layer_dim    = NL'($urandom);
      bg_pixel     = CW'($urandom);
   endtask

   // One clock: drive pix_ce, advance the model, return just after the rising edge.
   task automatic drive_cycle(input bit ce);
      int h, v;
      @(negedge clka);
      pix_ce = ce;
      if (ce) begin
         h = n % HT;
         v = (n / HT) % VT;
         exp_rgb = (h < HA && v < VA) ? compose(layer_pixel, layer_en, layer_key_en, layer_blink,
                                                layer_dim, bg_pixel, phase_of(n)) : 12'h000;
         exp_hs = (h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
         exp_vs = (v >= VA + VF && v < VA + VF + VS) ? POL : ~POL;
         n++;
      end
      @(posedge clka);
      #1;
   endtask

   task automatic model_reset();
      n = 0;
      exp_rgb = '0;
      exp_hs = ~POL;
      exp_vs = ~POL;
   endtask

   task automatic apply_reset();
      @(posedge clka);
      #3;
      rst = 1'b0;
      pix_ce = 1'b0;
      #1;
      model_reset();
      @(posedge clka);
      #2;
      rst = 1'b1;
   endtask

   task automatic seek(input int lo, input int hi, input bit need_v);
      int guard;
      guard = 0;
      while (!((n % HT) >= lo && (n % HT) <= hi && (!need_v || ((n / HT) % VT) < VA)) && guard <= FT) begin
         drive_cycle(1'b1);
         guard++;
      end
      if (guard > FT) begin
         fails++;
         $display("FAIL seek: position h in [%0d,%0d] not reached within %0d cycles", lo, hi, FT);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({h_cnt, v_cnt, valid, frame_start, hsync, vsync, rgb_out} !==
          {10'd0, 10'd0, 1'b1, 1'b1, ~POL, ~POL, 12'h000}) begin
         fails++;
         $display("FAIL reset_state: got h=%0d v=%0d vld=%b fs=%b hs=%b vs=%b rgb=%h, need 0/0/1/1/%b/%b/000",
                  h_cnt, v_cnt, valid, frame_start, hsync, vsync, rgb_out, ~POL, ~POL);
      end
   endtask

   task automatic test_timing();
      int hs_cnt, fs_gap;
      logic prev_hs;
      logic [9:0] prev_h;
      apply_reset();
      hs_cnt = 0; fs_gap = 0; prev_hs = hsync; prev_h = h_cnt;
      for (int c = 0; c < 2 * FT; c++) begin
         rand_inputs();
         drive_cycle(1'b1);
         fs_gap++;
         checks++;
         if ({h_cnt, v_cnt, valid, frame_start, hsync, vsync, rgb_out} !== exp_status()) begin
            fails++;
            $display("FAIL timing_status: got %h required %h at cycle %0d",
                     {h_cnt, v_cnt, valid, frame_start, hsync, vsync, rgb_out}, exp_status(), c);
         end
         if (hsync === POL) hs_cnt++;
         if (hsync === POL && prev_hs !== POL) begin
            checks++;
            if (prev_h !== 10'(HA + HF)) begin
               fails++;
               $display("FAIL hsync_start: prior h_cnt=%0d required %0d", prev_h, HA + HF);
            end
         end
         if (h_cnt == 10'd0) begin
            checks++;
            if (hs_cnt !== HS) begin
               fails++;
               $display("FAIL hsync_width: got %0d required %0d", hs_cnt, HS);
            end
            hs_cnt = 0;
         end
         if (frame_start === 1'b1) begin
            checks++;
            if (fs_gap !== FT) begin
               fails++;
               $display("FAIL frame_len: got %0d required %0d", fs_gap, FT);
            end
            fs_gap = 0;
         end
         prev_hs = hsync;
         prev_h  = h_cnt;
      end
   endtask

   task automatic test_priority();
      seek(1, HA - 3, 1'b1);
      layer_key_en = '0; layer_blink = '0; layer_dim = '0; bg_pixel = 12'h456;
      layer_pixel = {12'h00F, 12'h00F, 12'h0F0, 12'hF00};
      layer_en = 4'b0011;
      drive_cycle(1'b1);
      checks++;
      if (rgb_out !== 12'hF00) begin
         fails++; $display("FAIL priority_l0: got %h required F00", rgb_out);
      end
      layer_en = 4'b0010;
      drive_cycle(1'b1);
      checks++;
      if (rgb_out !== 12'h0F0) begin
         fails++; $display("FAIL priority_l1: got %h required 0F0", rgb_out);
      end
   endtask

   task automatic test_transparency();
      seek(1, HA - 4, 1'b1);
      layer_blink = '0; layer_dim = '0; bg_pixel = 12'h123;
      layer_pixel = {12'h00F, 12'h0FF, 12'h0F0, 12'hF0F};
      layer_en = 4'b0011; layer_key_en = 4'b0001;
      drive_cycle(1'b1);
      checks++;
      if (rgb_out !== 12'h0F0) begin
         fails++; $display("FAIL key_l0: got %h required 0F0", rgb_out);
      end
      layer_pixel = {12'h00F, 12'h0FF, 12'hF0F, 12'hF0F};
      layer_key_en = 4'b0011;
      drive_cycle(1'b1);
      checks++;
      if (rgb_out !== 12'h123) begin
         fails++; $display("FAIL key_all_bg: got %h required 123", rgb_out);
      end
      layer_en = 4'b0000;
      drive_cycle(1'b1);
      checks++;
      if (rgb_out !== 12'h123) begin
         fails++; $display("FAIL disabled_bg: got %h required 123", rgb_out);
      end
   endtask

   task automatic test_dim_blank();
      seek(1, HA - 3, 1'b1);
      layer_blink = '0; layer_key_en = '0; bg_pixel = 12'h321;
      layer_pixel = {12'h111, 12'h222, 12'h333, 12'hFA6};
      layer_en = 4'b0001; layer_dim = 4'b0001;
      drive_cycle(1'b1);
      checks++;
      if (rgb_out !== 12'h753) begin
         fails++; $display("FAIL dim: got %h required 753", rgb_out);
      end
      seek(HA + 1, HA + 1, 1'b0);
      layer_en = 4'b1111; layer_dim = 4'b0000;
      drive_cycle(1'b1);
      checks++;
      if (rgb_out !== 12'h000) begin
         fails++; $display("FAIL blank: got %h required 000", rgb_out);
      end
   endtask

   task automatic test_blink();
      int h, v, f;
      logic [11:0] l0, want;
      apply_reset();
      layer_en = 4'b0001; layer_blink = 4'b0001; layer_key_en = '0; layer_dim = '0;
      for (int c = 0; c < 6 * FT; c++) begin
         bg_pixel = CW'($urandom);
         l0 = bg_pixel ^ 12'(1 + $urandom_range(0, 4094));
         layer_pixel = {36'($urandom), l0};
         h = n % HT; v = (n / HT) % VT; f = n / FT;
         want = (h < HA && v < VA) ? ((f == 2 || f == 3) ? bg_pixel : l0) : 12'h000;
         drive_cycle(1'b1);
         if (h < HA && v < VA) begin
            checks++;
            if (rgb_out !== want) begin
               fails++;
               $display("FAIL blink: frame %0d h=%0d v=%0d got %h required %h", f, h, v, rgb_out, want);
            end
         end
      end
   endtask

   task automatic test_pix_ce();
      for (int c = 0; c < 4 * 120; c++) begin
         rand_inputs();
         drive_cycle(c % 4 == 0);
         checks++;
         if ({h_cnt, v_cnt, valid, frame_start, hsync, vsync, rgb_out} !== exp_status()) begin
            fails++;
            $display("FAIL pix_ce_status: got %h required %h at clock %0d",
                     {h_cnt, v_cnt, valid, frame_start, hsync, vsync, rgb_out}, exp_status(), c);
         end
      end
   endtask

   task automatic test_reset_midline();
      rand_inputs();
      seek(HA + HF + 2, HA + HF + 2, 1'b0);
      checks++;
      if (hsync !== POL) begin
         fails++; $display("FAIL pre_reset_hsync: got %b required %b", hsync, POL);
      end
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({h_cnt, v_cnt, hsync, vsync, rgb_out} !== {10'd0, 10'd0, ~POL, ~POL, 12'h000}) begin
         fails++;
         $display("FAIL midline_reset: got h=%0d v=%0d hs=%b vs=%b rgb=%h required 0/0/%b/%b/000",
                  h_cnt, v_cnt, hsync, vsync, rgb_out, ~POL, ~POL);
      end
      @(posedge clka);
      #2;
      rst = 1'b1;
      drive_cycle(1'b1);
      checks++;
      if ({h_cnt, v_cnt, valid, frame_start, hsync, vsync, rgb_out} !== exp_status()) begin
         fails++;
         $display("FAIL post_reset_step: got %h required %h",
                  {h_cnt, v_cnt, valid, frame_start, hsync, vsync, rgb_out}, exp_status());
      end
   endtask

   initial begin
      test_reset();
      test_timing();
      test_priority();
      test_transparency();
      test_dim_blank();
      test_blink();
      test_pix_ce();
      test_reset_midline();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
